// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_pkg : widths, GF(2^8) helpers and FSM encoding for the MixColumns engine |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aes_pkg;

    localparam int         STATE_W  = 128;
    localparam int         COL_W    = 32;
    localparam int         BYTE_W   = 8;
    localparam int         NUM_COLS = 4;
    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [BYTE_W-1:0]  byte_t;
    typedef logic [COL_W-1:0]   col_t;
    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    function automatic byte_t xtime(input byte_t b);
        return {b[BYTE_W-2:0], 1'b0} ^ (AES_POLY & {BYTE_W{b[BYTE_W-1]}});
    endfunction

    function automatic byte_t mul3(input byte_t b);
        return xtime(b) ^ b;
    endfunction

    // Column 0 occupies the most significant 32 bits of the state.
    function automatic col_t get_col(input state_t s, input logic [1:0] idx);
        case (idx)
            2'd0:    return s[127:96];
            2'd1:    return s[95:64];
            2'd2:    return s[63:32];
            default: return s[31:0];
        endcase
    endfunction

    function automatic state_t put_col(input state_t s, input logic [1:0] idx, input col_t c);
        state_t r;
        r = s;
        case (idx)
            2'd0:    r[127:96] = c;
            2'd1:    r[95:64]  = c;
            2'd2:    r[63:32]  = c;
            default: r[31:0]   = c;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_columns_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mix_columns_seq_if : input and output valid/ready streams of the engine    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mix_columns_seq_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_state;
    logic               in_bypass;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;

    modport master (
        output in_valid, in_state, in_bypass, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_bypass, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface
`default_nettype wire

// File: rtl/mix_columns_seq_mix_column.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mix_column : combinational AES MixColumns transform of one 32-bit column   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mix_column
    import aes_pkg::*;
(
    input  col_t i_col,
    output col_t o_col
);

    byte_t w_a0, w_a1, w_a2, w_a3;
    byte_t w_b0, w_b1, w_b2, w_b3;

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    assign w_b0 = xtime(w_a0) ^ mul3(w_a1) ^ w_a2        ^ w_a3;
    assign w_b1 = w_a0        ^ xtime(w_a1) ^ mul3(w_a2) ^ w_a3;
    assign w_b2 = w_a0        ^ w_a1        ^ xtime(w_a2) ^ mul3(w_a3);
    assign w_b3 = mul3(w_a0)  ^ w_a1        ^ w_a2        ^ xtime(w_a3);

    assign o_col = {w_b0, w_b1, w_b2, w_b3};

endmodule
`default_nettype wire

// File: rtl/mix_columns_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mix_columns_seq : iterative MixColumns, COLS_PER_CYCLE columns per clock   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_seq_if.slave  bus
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == NUM_COLS)) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [2:0] C_STEP = 3'(COLS_PER_CYCLE);

    mc_state_e  state_q, state_d;
    logic [1:0] col_cnt_q, col_cnt_d;
    state_t     work_q, work_d;
    logic       in_ready_q, out_valid_q;

    col_t       w_col_in  [COLS_PER_CYCLE];
    col_t       w_col_out [COLS_PER_CYCLE];
    logic [2:0] w_sum;

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign w_col_in[g] = get_col(work_q, col_cnt_q + 2'(g));
        mix_column u_mix (
            .i_col (w_col_in[g]),
            .o_col (w_col_out[g])
        );
    end

    // Carry out of the 2-bit counter marks the final column group.
    assign w_sum = {1'b0, col_cnt_q} + C_STEP;

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        work_d    = work_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    work_d    = bus.in_state;
                    col_cnt_d = 2'd0;
                    state_d   = bus.in_bypass ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    work_d = put_col(work_d, col_cnt_q + 2'(g), w_col_out[g]);
                end
                col_cnt_d = w_sum[1:0];
                if (w_sum[2]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_cnt_q   <= 2'd0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            work_q      <= work_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = work_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mix_columns_seq : directed and random checks of the MixColumns engine   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mix_columns_seq;
    import aes_pkg::*;

    localparam logic [127:0] C_FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] C_FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] C_VEC2_IN  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [127:0] C_VEC2_OUT = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mix_columns_seq_if bus1 ();
    mix_columns_seq_if bus2 ();
    mix_columns_seq_if bus4 ();

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent GF(2^8) reference: shift-and-add multiply.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mat_ref(input logic [127:0] st, input logic [7:0] k0,
                                             input logic [7:0] k1, input logic [7:0] k2,
                                             input logic [7:0] k3);
        logic [127:0] res;
        logic [31:0]  c;
        logic [7:0]   a0, a1, a2, a3;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            c = 32'(st >> (96 - 32 * i));
            {a0, a1, a2, a3} = c;
            res = {res[95:0],
                   gm(a0, k0) ^ gm(a1, k1) ^ gm(a2, k2) ^ gm(a3, k3),
                   gm(a0, k3) ^ gm(a1, k0) ^ gm(a2, k1) ^ gm(a3, k2),
                   gm(a0, k2) ^ gm(a1, k3) ^ gm(a2, k0) ^ gm(a3, k1),
                   gm(a0, k1) ^ gm(a1, k2) ^ gm(a2, k3) ^ gm(a3, k0)};
        end
        return res;
    endfunction

    function automatic logic [127:0] mc_ref(input logic [127:0] st);
        return mat_ref(st, 8'h02, 8'h03, 8'h01, 8'h01);
    endfunction

    function automatic logic [127:0] imc_ref(input logic [127:0] st);
        return mat_ref(st, 8'h0e, 8'h0b, 8'h0d, 8'h09);
    endfunction

    function automatic logic get_ov(input int w);
        case (w)
            1:       return bus1.out_valid;
            2:       return bus2.out_valid;
            default: return bus4.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int w);
        case (w)
            1:       return bus1.in_ready;
            2:       return bus2.in_ready;
            default: return bus4.in_ready;
        endcase
    endfunction

    function automatic logic [127:0] get_os(input int w);
        case (w)
            1:       return bus1.out_state;
            2:       return bus2.out_state;
            default: return bus4.out_state;
        endcase
    endfunction

    task automatic drive_in(input int w, input logic v, input logic [127:0] s, input logic b);
        case (w)
            1:       begin bus1.in_valid = v; bus1.in_state = s; bus1.in_bypass = b; end
            2:       begin bus2.in_valid = v; bus2.in_state = s; bus2.in_bypass = b; end
            default: begin bus4.in_valid = v; bus4.in_state = s; bus4.in_bypass = b; end
        endcase
    endtask

    task automatic drive_or(input int w, input logic r);
        case (w)
            1:       bus1.out_ready = r;
            2:       bus2.out_ready = r;
            default: bus4.out_ready = r;
        endcase
    endtask

    // Samples are taken on falling edges; the first one follows the accept edge.
    // Bypass raises out_valid on the accept edge (sample 1); otherwise on the
    // N-th edge after accept (sample N+1).
    task automatic run_block(input int w, input string tag, input logic [127:0] s,
                             input logic b, input logic [127:0] exp, input int hold);
        int m;
        int exp_m;
        exp_m = b ? 1 : (4 / w) + 1;
        @(negedge clk);
        drive_in(w, 1'b1, s, b);
        @(posedge clk);
        #1 drive_in(w, 1'b0, '0, 1'b0);
        @(negedge clk);
        m = 1;
        check({tag, "_ir_busy"}, 128'(get_ir(w)), 128'(0));
        while (!get_ov(w) && m < 20) begin
            @(negedge clk);
            m++;
        end
        check({tag, "_latency"}, 128'(m), 128'(exp_m));
        check({tag, "_state"}, get_os(w), exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_ov"}, 128'(get_ov(w)), 128'(1));
            check({tag, "_hold_os"}, get_os(w), exp);
            check({tag, "_hold_ir"}, 128'(get_ir(w)), 128'(0));
        end
        drive_or(w, 1'b1);
        @(posedge clk);
        #1 drive_or(w, 1'b0);
        @(negedge clk);
        check({tag, "_idle_ir"}, 128'(get_ir(w)), 128'(1));
        check({tag, "_idle_ov"}, 128'(get_ov(w)), 128'(0));
    endtask

    task automatic rand_run(input int w);
        logic [127:0] exp_q [$];
        logic [127:0] src_q [$];
        logic         byp_q [$];
        logic [127:0] cs, o, e, src;
        logic         cv, cb, r, eb, hold;
        int           n_in, n_out, cyc;
        cv = 1'b0; cb = 1'b0; cs = '0; hold = 1'b0;
        n_in = 0; n_out = 0; cyc = 0;
        while (n_out < 16 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                cv = (n_in < 16) && 1'($urandom_range(0, 1));
                cs = {$urandom(), $urandom(), $urandom(), $urandom()};
                cb = ($urandom_range(0, 3) == 0);
                drive_in(w, cv, cs, cb);
            end
            r = 1'($urandom_range(0, 1));
            drive_or(w, r);
            if (get_ov(w) && r) begin
                o = get_os(w);
                check("rnd_inflight", 128'(exp_q.size()), 128'(1));
                if (exp_q.size() > 0) begin
                    e   = exp_q.pop_front();
                    src = src_q.pop_front();
                    eb  = byp_q.pop_front();
                    check("rnd_state", o, e);
                    if (!eb) check("rnd_roundtrip", imc_ref(o), src);
                end
                n_out++;
            end
            if (cv && get_ir(w)) begin
                exp_q.push_back(cb ? cs : mc_ref(cs));
                src_q.push_back(cs);
                byp_q.push_back(cb);
                n_in++;
                hold = 1'b0;
            end else begin
                hold = cv;
            end
        end
        @(negedge clk);
        drive_in(w, 1'b0, '0, 1'b0);
        drive_or(w, 1'b0);
        check("rnd_count", 128'(n_out), 128'(16));
        check("rnd_leftover", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        logic [127:0] rs;
        for (int w = 1; w <= 4; w = w * 2) begin
            drive_in(w, 1'b0, '0, 1'b0);
            drive_or(w, 1'b0);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ir",  128'(bus1.in_ready),  128'(1));
        check("rst_ov",  128'(bus1.out_valid), 128'(0));
        check("rst_os",  bus1.out_state,       '0);
        check("rst_ir4", 128'(bus4.in_ready),  128'(1));
        rst_n = 1'b1;
        @(negedge clk);

        run_block(1, "fips_c1", C_FIPS_IN, 1'b0, C_FIPS_OUT, 0);
        run_block(2, "fips_c2", C_FIPS_IN, 1'b0, C_FIPS_OUT, 0);
        run_block(4, "fips_c4", C_FIPS_IN, 1'b0, C_FIPS_OUT, 0);
        run_block(2, "vec2_c2", C_VEC2_IN, 1'b0, C_VEC2_OUT, 0);

        run_block(1, "bp_c1", C_VEC2_IN, 1'b0, C_VEC2_OUT, 10);

        rs = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block(1, "byp_c1", rs, 1'b1, rs, 0);
        rs = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block(4, "byp_c4", rs, 1'b1, rs, 0);

        // Abort a block two columns in; nothing of it may surface afterwards.
        @(negedge clk);
        drive_in(1, 1'b1, C_FIPS_IN, 1'b0);
        @(posedge clk);
        #1 drive_in(1, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ov", 128'(bus1.out_valid), 128'(0));
        check("arst_ir", 128'(bus1.in_ready),  128'(1));
        check("arst_os", bus1.out_state,       '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(1, "post_rst", C_VEC2_IN, 1'b0, C_VEC2_OUT, 0);

        rand_run(1);
        rand_run(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
